neuron_seq_ctrl: RTL



---
 rtl/nn_pkg.sv | 19 +
 rtl/mac_pipe.sv | 45 ++++
 rtl/neuron_seq_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the neuron datapath.
package nn_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 12;

  typedef enum logic [2:0] {StIdle, StAccum, StDrain, StBias, StOut} state_t;

  // Clamp a wide signed value into the signed DATA_W range.
  function automatic logic [DATA_W-1:0] sat_dw(input logic signed [63:0] x);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (DATA_W - 1));
    if (x > hi) return hi[DATA_W-1:0];
    if (x < lo) return lo[DATA_W-1:0];
    return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply / accumulate pipeline with per-stage valid bits.
module mac_pipe import nn_pkg::*; #(
  parameter int unsigned ACC_W = 2 * DATA_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [DATA_W-1:0]       w_rdata,
  output logic signed [ACC_W-1:0] acc,
  output logic                    busy
);

  logic signed [DATA_W-1:0]   in_q;
  logic                       in_vld_q;
  logic signed [2*DATA_W-1:0] prod_q;
  logic                       prod_vld_q;
  logic signed [ACC_W-1:0]    acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q       <= '0;
      in_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      in_vld_q <= en;
      if (en) in_q <= $signed(in_data);
      // Weight arrives one cycle after the read, aligned with the registered input.
      prod_vld_q <= in_vld_q;
      if (in_vld_q) prod_q <= in_q * $signed(w_rdata);
      if (clr) begin
        acc_q <= '0;
      end else if (prod_vld_q) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
    end
  end

  assign acc  = acc_q;
  assign busy = in_vld_q | prod_vld_q;

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Frame sequencer for one fully connected neuron: drives weight reads, MAC and bias/saturate.
module neuron_seq_ctrl import nn_pkg::*; #(
  parameter int unsigned NUM_WEIGHT = 30,
  parameter int unsigned ADDR_W     = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] bias,
  output logic              w_ren,
  output logic [ADDR_W-1:0] w_radd,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned     AccW    = 2 * DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_WEIGHT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                drain_q, drain_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                acc_en, acc_clr, pipe_busy;
  logic signed [AccW-1:0] acc, biased;

  assign in_ready = (state_q == StIdle) || (state_q == StAccum);
  assign acc_en   = in_valid & in_ready;
  assign w_ren    = acc_en;
  assign w_radd   = idx_q;
  assign biased   = acc + (AccW'($signed(bias)) <<< FRAC_BITS);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drain_d     = 1'b0;
    acc_clr     = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (acc_en) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDrain;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StAccum;
          end
        end
      end
      // Two cycles lets the last product reach the accumulator.
      StDrain: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = StBias;
      end
      StBias: begin
        out_data_d  = sat_dw(64'(biased >>> FRAC_BITS));
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        acc_clr = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  mac_pipe #(
    .ACC_W(AccW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (acc_en),
    .clr    (acc_clr),
    .in_data(in_data),
    .w_rdata(w_rdata),
    .acc    (acc),
    .busy   (pipe_busy)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle) | pipe_busy;

endmodule
